panda_risc_v_div_dispatch: RTL and testbench

Issue/retire shim between the EXU decode stage and the 33-bit multi-cycle divider. It decodes RISC-V M-extension DIV/DIVU/REM/REMU requests and sign- or zero-extends the operands to 33 bits for the divider. It tracks the rd index of every in-flight divide in an in-order tag queue. Divider results are paired with their tags and presented on a registered writeback port, and a pipeline flush discards all uncommitted divides.

---
 rtl/panda_risc_v_div_pkg.sv | 21 ++
 rtl/panda_risc_v_div_tag_fifo.sv | 84 ++++++++
 rtl/panda_risc_v_div_dispatch.sv | 128 ++++++++++++
 tb/tb_panda_risc_v_div_dispatch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_risc_v_div_pkg.sv
// Shared definitions for the divide dispatch shim.
// - funct3 bit positions used to decode DIV/DIVU/REM/REMU
// - tag entry layout {discard, rd_id[4:0]} with field indices
// - operand extension helper for the 33-bit divider
package panda_risc_v_div_pkg;

  localparam int unsigned FUNCT3_UNSIGNED_BIT = 0;
  localparam int unsigned FUNCT3_REM_BIT      = 1;

  localparam int unsigned DIV_TAG_W       = 6;
  localparam int unsigned TAG_RD_LSB      = 0;
  localparam int unsigned TAG_RD_MSB      = 4;
  localparam int unsigned TAG_DISCARD_BIT = 5;

  // Signed ops replicate bit 31 into bit 32; unsigned ops zero-extend.
  function automatic logic [32:0] div_ext33(input logic [31:0] v,
                                            input logic        is_unsigned);
    return {~is_unsigned & v[31], v};
  endfunction

endpackage

// File: rtl/panda_risc_v_div_tag_fifo.sv
// In-order tag queue for in-flight divides.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   push, push_tag    write a tag (ignored when full)
//   pop               drop the head tag (ignored when empty)
//   mark_discard      set the discard bit of every stored entry
//   head_tag          entry at the read pointer
//   count, full, empty occupancy and flags
module panda_risc_v_div_tag_fifo
  import panda_risc_v_div_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 push,
  input  logic [DIV_TAG_W-1:0] push_tag,
  input  logic                 pop,
  input  logic                 mark_discard,
  output logic [DIV_TAG_W-1:0] head_tag,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DIV_TAG_W-1:0] mem_q [DEPTH];
  logic [DIV_TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_tag = mem_q[rptr_q];

  // Flags are from the start of the cycle, so a pop never frees room for
  // a push in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    // Marking touches stale slots too; they are overwritten on push anyway.
    if (mark_discard) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i][TAG_DISCARD_BIT] = 1'b1;
      end
    end
    if (push_ok) begin
      mem_d[wptr_q] = push_tag;
    end
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wptr_d = wptr_q + PTR_W'(push_ok);
    rptr_d = rptr_q + PTR_W'(pop_ok);
    cnt_d  = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/panda_risc_v_div_dispatch.sv
// Issue/retire shim between EXU decode and the 33-bit multi-cycle divider.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   s_req_*            decoded DIV/DIVU/REM/REMU request from decode
//   m_div_req_*        extended operands and quotient/remainder select
//   s_div_res_*        divider result stream (in issue order)
//   m_wb_*             registered writeback port
//   flush              kill all uncommitted divides
//   outstanding_cnt    number of divides in flight
//   busy               work in flight or writeback pending
module panda_risc_v_div_dispatch
  import panda_risc_v_div_pkg::*;
#(
  parameter int          simulation_delay = 1,
  parameter int unsigned max_outstanding  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_req_op1,
  input  logic [31:0] s_req_op2,
  input  logic [1:0]  s_req_funct3,
  input  logic [4:0]  s_req_rd_id,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  output logic [32:0] m_div_req_op_a,
  output logic [32:0] m_div_req_op_b,
  output logic        m_div_req_rem_sel,
  output logic        m_div_req_valid,
  input  logic        m_div_req_ready,
  input  logic [31:0] s_div_res_data,
  input  logic        s_div_res_valid,
  output logic        s_div_res_ready,
  output logic [31:0] m_wb_data,
  output logic [4:0]  m_wb_rd_id,
  output logic        m_wb_valid,
  input  logic        m_wb_ready,
  input  logic        flush,
  output logic [3:0]  outstanding_cnt,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(max_outstanding) + 1;

  // Registers update exactly at the clock edge; the delay is not modelled.
  if (simulation_delay < 0) begin : g_negative_sim_delay
  end

  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop;
  logic [DIV_TAG_W-1:0] push_tag, head_tag;
  logic [CNT_W-1:0]     fifo_count;
  logic                 head_discard;
  logic                 load_wb;

  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_id_q, wb_rd_id_d;

  // Request side: zero added latency.
  assign m_div_req_op_a    = div_ext33(s_req_op1, s_req_funct3[FUNCT3_UNSIGNED_BIT]);
  assign m_div_req_op_b    = div_ext33(s_req_op2, s_req_funct3[FUNCT3_UNSIGNED_BIT]);
  assign m_div_req_rem_sel = s_req_funct3[FUNCT3_REM_BIT];
  assign m_div_req_valid   = s_req_valid & ~fifo_full & ~flush;
  assign s_req_ready       = m_div_req_ready & ~fifo_full & ~flush;
  assign fifo_push         = s_req_valid & s_req_ready;

  always_comb begin
    push_tag                        = '0;
    push_tag[TAG_RD_MSB:TAG_RD_LSB] = s_req_rd_id;
    push_tag[TAG_DISCARD_BIT]       = 1'b0;
  end

  // Result side: discarded results (or those killed by flush) never need the
  // writeback register, so they may pop even while it is stalled.
  assign head_discard    = head_tag[TAG_DISCARD_BIT];
  assign s_div_res_ready = ~fifo_empty & (head_discard | flush | ~wb_valid_q | m_wb_ready);
  assign fifo_pop        = s_div_res_valid & s_div_res_ready;
  assign load_wb         = fifo_pop & ~head_discard & ~flush;

  panda_risc_v_div_tag_fifo #(
    .DEPTH (max_outstanding),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (fifo_push),
    .push_tag     (push_tag),
    .pop          (fifo_pop),
    .mark_discard (flush),
    .head_tag     (head_tag),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_id_d = wb_rd_id_q;
    if (load_wb) begin
      wb_valid_d = 1'b1;
      wb_data_d  = s_div_res_data;
      wb_rd_id_d = head_tag[TAG_RD_MSB:TAG_RD_LSB];
    end else if (flush || m_wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    wb_data_q  <= wb_data_d;
    wb_rd_id_q <= wb_rd_id_d;
  end

  assign m_wb_valid      = wb_valid_q;
  assign m_wb_data       = wb_data_q;
  assign m_wb_rd_id      = wb_rd_id_q;
  assign outstanding_cnt = 4'(fifo_count);
  assign busy            = (fifo_count != '0) | wb_valid_q;

endmodule

// File: tb/tb_panda_risc_v_div_dispatch.sv
module tb_panda_risc_v_div_dispatch;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_req_op1, s_req_op2;
  logic [1:0]  s_req_funct3;
  logic [4:0]  s_req_rd_id;
  logic        s_req_valid, s_req_ready;
  logic [32:0] m_div_req_op_a, m_div_req_op_b;
  logic        m_div_req_rem_sel, m_div_req_valid, m_div_req_ready;
  logic [31:0] s_div_res_data;
  logic        s_div_res_valid, s_div_res_ready;
  logic [31:0] m_wb_data;
  logic [4:0]  m_wb_rd_id;
  logic        m_wb_valid, m_wb_ready;
  logic        flush;
  logic [3:0]  outstanding_cnt;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected writebacks {rd_id, data}, in order.
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  panda_risc_v_div_dispatch #(
    .simulation_delay (1),
    .max_outstanding  (4)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .s_req_op1         (s_req_op1),
    .s_req_op2         (s_req_op2),
    .s_req_funct3      (s_req_funct3),
    .s_req_rd_id       (s_req_rd_id),
    .s_req_valid       (s_req_valid),
    .s_req_ready       (s_req_ready),
    .m_div_req_op_a    (m_div_req_op_a),
    .m_div_req_op_b    (m_div_req_op_b),
    .m_div_req_rem_sel (m_div_req_rem_sel),
    .m_div_req_valid   (m_div_req_valid),
    .m_div_req_ready   (m_div_req_ready),
    .s_div_res_data    (s_div_res_data),
    .s_div_res_valid   (s_div_res_valid),
    .s_div_res_ready   (s_div_res_ready),
    .m_wb_data         (m_wb_data),
    .m_wb_rd_id        (m_wb_rd_id),
    .m_wb_valid        (m_wb_valid),
    .m_wb_ready        (m_wb_ready),
    .flush             (flush),
    .outstanding_cnt   (outstanding_cnt),
    .busy              (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && m_wb_valid === 1'b1 && m_wb_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected none", m_wb_rd_id, m_wb_data);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_rd", 64'(m_wb_rd_id), 64'(e[36:32]));
        chk("wb_data", 64'(m_wb_data), 64'(e[31:0]));
      end
    end
  end

  task automatic issue(input logic [31:0] op1, input logic [31:0] op2, input logic [1:0] f3,
                       input logic [4:0] rd, input logic [32:0] ea, input logic [32:0] eb,
                       input logic er);
    int n;
    s_req_op1 = op1; s_req_op2 = op2; s_req_funct3 = f3; s_req_rd_id = rd;
    s_req_valid = 1'b1;
    #1;
    chk("op_a", 64'(m_div_req_op_a), 64'(ea));
    chk("op_b", 64'(m_div_req_op_b), 64'(eb));
    chk("rem_sel", 64'(m_div_req_rem_sel), 64'(er));
    n = 0;
    while (s_req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("req_ready", 64'(s_req_ready), 64'(1));
    chk("div_req_valid", 64'(m_div_req_valid), 64'(1));
    tick();
    s_req_valid = 1'b0;
  endtask

  task automatic result(input logic [31:0] data, input logic [4:0] rd,
                        input logic push_exp, input logic exp_valid);
    int n;
    s_div_res_data = data; s_div_res_valid = 1'b1;
    #1;
    n = 0;
    while (s_div_res_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("res_ready", 64'(s_div_res_ready), 64'(1));
    if (push_exp) sb.push_back({rd, data});
    tick();
    s_div_res_valid = 1'b0;
    chk("wb_valid_after_pop", 64'(m_wb_valid), 64'(exp_valid));
    if (exp_valid) chk("wb_rd_after_pop", 64'(m_wb_rd_id), 64'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    s_req_op1 = '0; s_req_op2 = '0; s_req_funct3 = '0; s_req_rd_id = '0; s_req_valid = 1'b0;
    m_div_req_ready = 1'b1; s_div_res_data = '0; s_div_res_valid = 1'b0;
    m_wb_ready = 1'b1; flush = 1'b0;
    #2;
    chk("rst_cnt", 64'(outstanding_cnt), 64'(0));
    chk("rst_wb_valid", 64'(m_wb_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res_ready", 64'(s_div_res_ready), 64'(0));
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Signed DIV -7/2
    issue(32'hFFFF_FFF9, 32'd2, 2'b00, 5'd5, 33'h1_FFFF_FFF9, 33'h0_0000_0002, 1'b0);
    chk("cnt_one", 64'(outstanding_cnt), 64'(1));
    chk("busy_one", 64'(busy), 64'(1));
    result(32'hFFFF_FFFD, 5'd5, 1'b1, 1'b1);
    tick();

    // DIVU then REMU, written back in order
    issue(32'hFFFF_FFF9, 32'd2, 2'b01, 5'd7, 33'h0_FFFF_FFF9, 33'h0_0000_0002, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 2'b11, 5'd8, 33'h0_FFFF_FFF9, 33'h0_0000_0002, 1'b1);
    result(32'h7FFF_FFFC, 5'd7, 1'b1, 1'b1);
    result(32'h0000_0001, 5'd8, 1'b1, 1'b1);
    tick();

    // Fill the tag queue; the 5th request waits a full cycle after a pop
    for (int i = 10; i < 14; i++)
      issue(32'(i), 32'd1, 2'b00, 5'(i), {1'b0, 32'(i)}, 33'd1, 1'b0);
    s_req_op1 = 32'd14; s_req_op2 = 32'd1; s_req_funct3 = 2'b00; s_req_rd_id = 5'd14;
    s_req_valid = 1'b1;
    #1;
    chk("full_req_ready", 64'(s_req_ready), 64'(0));
    chk("full_div_valid", 64'(m_div_req_valid), 64'(0));
    chk("full_cnt", 64'(outstanding_cnt), 64'(4));
    s_div_res_data = 32'hA0; s_div_res_valid = 1'b1;
    #1;
    chk("full_pop_res_ready", 64'(s_div_res_ready), 64'(1));
    chk("full_pop_req_ready", 64'(s_req_ready), 64'(0));
    sb.push_back({5'd10, 32'hA0});
    tick();
    s_div_res_valid = 1'b0;
    #1;
    chk("after_pop_req_ready", 64'(s_req_ready), 64'(1));
    chk("after_pop_cnt", 64'(outstanding_cnt), 64'(3));
    tick();
    s_req_valid = 1'b0;
    chk("refill_cnt", 64'(outstanding_cnt), 64'(4));
    for (int i = 11; i < 15; i++)
      result(32'hA0 + 32'(i - 10), 5'(i), 1'b1, 1'b1);
    tick(); tick();

    // Writeback backpressure
    m_wb_ready = 1'b0;
    issue(32'd100, 32'd3, 2'b00, 5'd20, 33'd100, 33'd3, 1'b0);
    issue(32'd100, 32'd3, 2'b10, 5'd21, 33'd100, 33'd3, 1'b1);
    result(32'h111, 5'd20, 1'b1, 1'b1);
    s_div_res_data = 32'h222; s_div_res_valid = 1'b1;
    #1;
    chk("bp_res_ready", 64'(s_div_res_ready), 64'(0));
    tick();
    chk("bp_hold_data", 64'(m_wb_data), 64'h111);
    chk("bp_hold_rd", 64'(m_wb_rd_id), 64'(20));
    chk("bp_res_ready2", 64'(s_div_res_ready), 64'(0));
    tick();
    chk("bp_hold_data2", 64'(m_wb_data), 64'h111);
    m_wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(s_div_res_ready), 64'(1));
    sb.push_back({5'd21, 32'h222});
    tick();
    s_div_res_valid = 1'b0;
    chk("bp_second_rd", 64'(m_wb_rd_id), 64'(21));
    tick(); tick();

    // Flush with three divides in flight
    issue(32'd1, 32'd1, 2'b00, 5'd1, 33'd1, 33'd1, 1'b0);
    issue(32'd2, 32'd1, 2'b00, 5'd2, 33'd2, 33'd1, 1'b0);
    issue(32'd3, 32'd1, 2'b00, 5'd3, 33'd3, 33'd1, 1'b0);
    s_req_op1 = 32'd31; s_req_rd_id = 5'd31; s_req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_req_ready", 64'(s_req_ready), 64'(0));
    chk("flush_div_valid", 64'(m_div_req_valid), 64'(0));
    tick();
    flush = 1'b0; s_req_valid = 1'b0;
    chk("flush_cnt", 64'(outstanding_cnt), 64'(3));
    result(32'hD1, 5'd1, 1'b0, 1'b0);
    result(32'hD2, 5'd2, 1'b0, 1'b0);
    result(32'hD3, 5'd3, 1'b0, 1'b0);
    chk("drained_cnt", 64'(outstanding_cnt), 64'(0));
    chk("drained_busy", 64'(busy), 64'(0));
    issue(32'd20, 32'd4, 2'b00, 5'd9, 33'd20, 33'd4, 1'b0);
    result(32'd5, 5'd9, 1'b1, 1'b1);
    tick(); tick();

    // Flush together with a result pop and a pending writeback
    m_wb_ready = 1'b0;
    issue(32'd7, 32'd7, 2'b00, 5'd16, 33'd7, 33'd7, 1'b0);
    issue(32'd8, 32'd7, 2'b00, 5'd17, 33'd8, 33'd7, 1'b0);
    result(32'h333, 5'd16, 1'b0, 1'b1);
    s_div_res_data = 32'h444; s_div_res_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_pop_ready", 64'(s_div_res_ready), 64'(1));
    tick();
    s_div_res_valid = 1'b0; flush = 1'b0;
    chk("flush_wb_cleared", 64'(m_wb_valid), 64'(0));
    chk("flush_pop_cnt", 64'(outstanding_cnt), 64'(0));
    chk("flush_pop_busy", 64'(busy), 64'(0));

    // Asynchronous reset mid-operation
    issue(32'd9, 32'd1, 2'b00, 5'd18, 33'd9, 33'd1, 1'b0);
    issue(32'd9, 32'd1, 2'b00, 5'd19, 33'd9, 33'd1, 1'b0);
    result(32'h555, 5'd18, 1'b0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_cnt", 64'(outstanding_cnt), 64'(0));
    chk("arst_wb_valid", 64'(m_wb_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_res_ready", 64'(s_div_res_ready), 64'(0));
    tick();
    resetn = 1'b1;
    m_wb_ready = 1'b1;
    tick(); tick();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
